// File: rtl/tmec_key_sched.sv
// tmec_key_sched: round-robin sequencer for the shared key-equation datapath.
// Grants one syndrome source at a time, pulses syn_done/ack, drives the
// iteration index bch_n and beta select bsel, tracks locator degree l, and
// returns owner/error count once the datapath raises ch_start.
// Optional watchdog: define TMEC_KEY_SCHED_TIMEOUT_EN to force DONE (fail=1)
// after 2*T+4 RUN cycles without ch_start.
module tmec_key_sched #(
   parameter int M = 4,
   parameter int T = 3,
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1,
   localparam int BW = $clog2(T + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  ack,
   output logic [IW-1:0] sel,
   output logic          syn_done,
   input  logic          next_l,
   input  logic          d_r_nonzero,
   input  logic          ch_start,
   output logic [BW-1:0] bch_n,
   output logic          bsel,
   output logic          done,
   input  logic          done_ready,
   output logic [IW-1:0] done_sel,
   output logic [BW:0]   err_cnt,
   output logic          fail
);

   // GF(2^M) symbol type; no symbol-wide logic lives in the sequencer
   typedef logic [M-1:0] gf_sym_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   localparam int unsigned NU = N;

   state_t          state, state_nx;
   logic [IW-1:0]   rr_ptr;
   logic [BW:0]     l;
   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic            timeout;

`ifdef TMEC_KEY_SCHED_TIMEOUT_EN
   localparam int WD_LIMIT = 2 * T + 4;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);
   logic [WD_W-1:0] wd_cnt;

   // Watchdog: cleared on LOAD, counts every RUN cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state == S_LOAD) begin
         wd_cnt <= '0;
      end else if (state == S_RUN) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = (state == S_RUN) && (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
   assign timeout = 1'b0;
`endif

   // Round-robin pick: first set req at or after rr_ptr, wrapping N-1 -> 0
   always_comb begin
      int unsigned idx;
      logic [IW-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      cand        = '0;
      for (int unsigned i = 0; i < NU; i++) begin
         idx = {{(32 - IW){1'b0}}, rr_ptr} + i;
         if (idx >= NU) idx = idx - NU;
         cand = IW'(idx);
         if (!grant_found && req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (grant_found) state_nx = S_LOAD;
         S_LOAD: state_nx = S_RUN;
         S_RUN:  if (ch_start || timeout) state_nx = S_DONE;
         S_DONE: if (done_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM-decoded outputs
   always_comb begin
      ack      = '0;
      syn_done = 1'b0;
      done     = 1'b0;
      bsel     = 1'b0;
      case (state)
         S_LOAD: begin
            syn_done = 1'b1;
            ack[sel] = 1'b1;
         end
         S_RUN:  bsel = !next_l && d_r_nonzero && ({1'b0, bch_n} >= l);
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Per-codeword registers: grant select, iteration index, degree, result
   always_ff @(posedge clk) begin
      if (reset) begin
         sel      <= '0;
         rr_ptr   <= '0;
         bch_n    <= '0;
         l        <= '0;
         err_cnt  <= '0;
         fail     <= 1'b0;
         done_sel <= '0;
      end else begin
         case (state)
            S_IDLE: if (grant_found) sel <= grant_idx;
            S_LOAD: begin
               bch_n  <= '0;
               l      <= '0;
               rr_ptr <= (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
            end
            S_RUN: begin
               // ch_start wins over a same-cycle shuffle; that update is dropped
               if (ch_start) begin
                  err_cnt  <= l;
                  fail     <= (l > (BW + 1)'(T));
                  done_sel <= sel;
               end else if (timeout) begin
                  err_cnt  <= l;
                  fail     <= 1'b1;
                  done_sel <= sel;
               end else if (!next_l) begin
                  if (bsel) l <= {bch_n, 1'b1} - l;
                  if (bch_n != BW'(T)) bch_n <= bch_n + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tmec_key_sched.sv
// tb_tmec_key_sched: table-driven vectors plus hand sequences for
// ch_start priority, reset mid-RUN, held round-robin and done back-pressure.
module tb_tmec_key_sched;

   localparam int M  = 4;
   localparam int T  = 3;
   localparam int N  = 2;
   localparam int IW = 1;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  ack;
   logic [IW-1:0] sel;
   logic          syn_done;
   logic          next_l;
   logic          d_r_nonzero;
   logic          ch_start;
   logic [BW-1:0] bch_n;
   logic          bsel;
   logic          done;
   logic          done_ready;
   logic [IW-1:0] done_sel;
   logic [BW:0]   err_cnt;
   logic          fail;

   tmec_key_sched #(.M(M), .T(T), .N(N)) dut (
      .clk(clk), .reset(reset), .req(req), .ack(ack), .sel(sel),
      .syn_done(syn_done), .next_l(next_l), .d_r_nonzero(d_r_nonzero),
      .ch_start(ch_start), .bch_n(bch_n), .bsel(bsel), .done(done),
      .done_ready(done_ready), .done_sel(done_sel), .err_cnt(err_cnt),
      .fail(fail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [4:0] dr;     // d_r_nonzero on shuffle k = dr[k]
      int         nshuf;
      int         esel;
      int         ecnt;
      int         efail;
   } vec_t;

   typedef struct {
      int dsel;
      int ecnt;
      int fl;
   } res_t;

   vec_t vec [7];
   res_t sbq [$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE: raise req, expect LOAD pulse with given owner, then RUN
   task automatic start_cw(input logic [1:0] r, input int exp_sel, input bit keep);
      req = r;
      tick();
      chk("syn_done_load", syn_done, 1);
      chk("ack_load", ack, 32'(1) << exp_sel);
      chk("sel_load", sel, exp_sel);
      req = keep ? r : '0;
      tick();
      chk("ack_run", ack, 0);
      chk("syn_done_run", syn_done, 0);
      chk("bch_n_start", bch_n, 0);
   endtask

   // One d_r cycle followed by one shuffle cycle; lm is the bench's degree
   task automatic shuffle(input logic dr, input int k, inout int lm);
      int  eb_n;
      logic eb;
      next_l = 1'b1;
      tick();
      chk("bsel_dr_cycle", bsel, 0);
      next_l = 1'b0;
      d_r_nonzero = dr;
      #1;
      eb_n = (k < T) ? k : T;
      chk("bch_n", bch_n, eb_n);
      eb = dr && (eb_n >= lm);
      chk("bsel", bsel, eb);
      tick();
      if (eb) lm = 2 * eb_n + 1 - lm;
      next_l = 1'b1;
      d_r_nonzero = 1'b0;
   endtask

   task automatic pop_check(output res_t e);
      e = '{0, 0, 0};
      if (!done) begin
         chk("done_latency", done, 1);
      end
      if (sbq.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         e = sbq.pop_front();
         chk("done_sel", done_sel, e.dsel);
         chk("err_cnt", err_cnt, e.ecnt);
         chk("fail", fail, e.fl);
      end
   endtask

   // Raise ch_start, expect done next cycle, hold back-pressure, then accept
   task automatic finish_cw(input int hold);
      res_t e;
      ch_start = 1'b1;
      tick();
      ch_start = 1'b0;
      pop_check(e);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("done_hold", done, 1);
         chk("done_sel_hold", done_sel, e.dsel);
         chk("err_cnt_hold", err_cnt, e.ecnt);
         chk("no_syn_done_in_done", syn_done, 0);
      end
      chk("no_syn_done_in_done", syn_done, 0);
      done_ready = 1'b1;
      tick();
      chk("done_clear", done, 0);
      done_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int   lm;
      vec_t v;
      res_t e;

      vec[0] = '{2'b01, 5'b00000, 3, 0, 0, 0};
      vec[1] = '{2'b01, 5'b00111, 3, 0, 3, 0};
      vec[2] = '{2'b10, 5'b00101, 3, 1, 4, 1};
      vec[3] = '{2'b11, 5'b00010, 3, 0, 3, 0};
      vec[4] = '{2'b11, 5'b00011, 3, 1, 2, 0};
      vec[5] = '{2'b10, 5'b00100, 3, 1, 5, 1};
      vec[6] = '{2'b01, 5'b10000, 5, 0, 7, 1};   // bch_n saturates at T

      reset = 1'b1; req = '0; next_l = 1'b1; d_r_nonzero = 1'b0;
      ch_start = 1'b0; done_ready = 1'b0;
      tick(); tick();
      chk("rst_ack", ack, 0);
      chk("rst_syn_done", syn_done, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_sel", sel, 0);
      chk("rst_done_sel", done_sel, 0);
      chk("rst_bch_n", bch_n, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_bsel", bsel, 0);
      reset = 1'b0;
      tick();
      chk("idle_no_syn_done", syn_done, 0);

      for (int i = 0; i < 7; i++) begin
         v = vec[i];
         sbq.push_back('{v.esel, v.ecnt, v.efail});
         start_cw(v.req, v.esel, 1'b0);
         lm = 0;
         for (int k = 0; k < v.nshuf; k++) shuffle(v.dr[k], k, lm);
         finish_cw(0);
      end

      // ch_start coincident with a shuffle that would have moved l and bch_n
      sbq.push_back('{0, 0, 0});
      start_cw(2'b01, 0, 1'b0);
      next_l = 1'b0; d_r_nonzero = 1'b1; ch_start = 1'b1;
      #1;
      chk("bsel_prio", bsel, 1);
      tick();
      ch_start = 1'b0; next_l = 1'b1; d_r_nonzero = 1'b0;
      chk("bch_n_prio_kept", bch_n, 0);
      pop_check(e);
      done_ready = 1'b1;
      tick();
      chk("done_clear_prio", done, 0);
      done_ready = 1'b0;

      // Reset while RUN with bch_n=1 abandons the codeword
      start_cw(2'b01, 0, 1'b0);
      lm = 0;
      shuffle(1'b0, 0, lm);
      chk("bch_n_before_rst", bch_n, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_run_done", done, 0);
      chk("rst_run_bch_n", bch_n, 0);
      chk("rst_run_ack", ack, 0);
      chk("rst_run_sel", sel, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_run_no_syn_done", syn_done, 0);
         chk("rst_run_no_done", done, 0);
      end

      // Both requesters held: grants alternate 0,1,0 from a fresh pointer
      for (int g = 0; g < 3; g++) begin
         sbq.push_back('{g % 2, 0, 0});
         start_cw(2'b11, g % 2, 1'b1);
         finish_cw(0);
      end
      req = '0;

      // Done back-pressure for 5 cycles while requester 1 waits
      sbq.push_back('{0, 3, 0});
      start_cw(2'b01, 0, 1'b0);
      lm = 0;
      for (int k = 0; k < 3; k++) shuffle(1'b1, k, lm);
      req = 2'b10;
      finish_cw(5);
      sbq.push_back('{1, 0, 0});
      start_cw(2'b10, 1, 1'b0);
      finish_cw(0);

      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
